arb_mux_reg: RTL and testbench



---
 rtl/arb_mux_reg_if.sv | 36 +++
 rtl/arb_mux_reg.sv | 107 ++++++++++
 tb/tb_arb_mux_reg.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/arb_mux_reg_if.sv
// rtl/arb_mux_reg_if.sv - handshake bundle for the arbitrating register mux
// Ports carried:
//   in_data   N*WIDTH  channel c at [c*WIDTH +: WIDTH]
//   in_valid  N        per-channel request
//   in_ready  N        per-channel accept, one-hot or zero
//   force_sel SELW     forced channel (MODE 2 only)
//   out_data  WIDTH    registered data
//   out_ch    SELW     channel that supplied out_data
//   out_valid 1        output register holds data
//   out_ready 1        downstream accepts out_data
interface arb_mux_reg_if #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = 3
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    force_sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    // Mux side
    modport slave (
        input  in_data, in_valid, force_sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    // Sources and sink side
    modport master (
        output in_data, in_valid, force_sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/arb_mux_reg.sv
// rtl/arb_mux_reg.sv - N-channel arbitrating mux with registered output stage
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    arb_mux_reg_if.slave (channel inputs, forced select, registered output)
// MODE: 0 round-robin, 1 fixed priority (lowest index), 2 forced via force_sel.
module arb_mux_reg #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = 3,
    parameter int MODE  = 0
) (
    input  logic            clk,
    input  logic            reset,
    arb_mux_reg_if.slave    bus
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q,      ptr_d;

    logic             le;
    logic [N-1:0]     elig;
    logic             any_elig;
    logic [SELW-1:0]  grant;
    logic             found;
    logic [N-1:0]     in_ready_d;
    int               idx;

    always_comb begin
        le       = !out_valid_q || bus.out_ready;
        elig     = '0;
        grant    = '0;
        found    = 1'b0;
        idx      = 0;

        // Forced mode only ever offers the selected channel; an out-of-range
        // force_sel matches no channel, so the output simply drains.
        if (MODE == 2) begin
            for (int c = 0; c < N; c++) begin
                if (bus.force_sel == SELW'(c)) elig[c] = bus.in_valid[c];
            end
        end else begin
            elig = bus.in_valid;
        end
        any_elig = |elig;

        if (MODE == 0) begin
            // Scan starting at ptr, wrapping at N rather than 2^SELW.
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N) idx = idx - N;
                if (!found && elig[idx]) begin
                    grant = SELW'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            // Lowest set bit; in forced mode elig has at most the force_sel bit.
            for (int i = N - 1; i >= 0; i--) begin
                if (elig[i]) grant = SELW'(i);
            end
        end

        in_ready_d = '0;
        if (le && any_elig && !reset) in_ready_d[grant] = 1'b1;

        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (le) begin
            if (any_elig) begin
                out_data_d  = bus.in_data[int'(grant)*WIDTH +: WIDTH];
                out_ch_d    = grant;
                out_valid_d = 1'b1;
                if (MODE == 0) begin
                    if (int'(grant) == N - 1) ptr_d = '0;
                    else                      ptr_d = grant + SELW'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb/tb_arb_mux_reg.sv - directed self-checking bench for arb_mux_reg
module tb_arb_mux_reg;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    arb_mux_reg_if #(.WIDTH(16), .N(8), .SELW(3)) i0 ();
    arb_mux_reg_if #(.WIDTH(16), .N(5), .SELW(3)) i5 ();
    arb_mux_reg_if #(.WIDTH(16), .N(8), .SELW(3)) i1 ();
    arb_mux_reg_if #(.WIDTH(16), .N(6), .SELW(3)) i2 ();

    arb_mux_reg #(.WIDTH(16), .N(8), .SELW(3), .MODE(0)) u_rr8 (.clk(clk), .reset(reset), .bus(i0));
    arb_mux_reg #(.WIDTH(16), .N(5), .SELW(3), .MODE(0)) u_rr5 (.clk(clk), .reset(reset), .bus(i5));
    arb_mux_reg #(.WIDTH(16), .N(8), .SELW(3), .MODE(1)) u_fp8 (.clk(clk), .reset(reset), .bus(i1));
    arb_mux_reg #(.WIDTH(16), .N(6), .SELW(3), .MODE(2)) u_fs6 (.clk(clk), .reset(reset), .bus(i2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        i0.in_valid = '0; i0.out_ready = 1'b0; i0.force_sel = '0; i0.in_data = '0;
        i5.in_valid = '0; i5.out_ready = 1'b0; i5.force_sel = '0; i5.in_data = '0;
        i1.in_valid = '0; i1.out_ready = 1'b0; i1.force_sel = '0; i1.in_data = '0;
        i2.in_valid = '0; i2.out_ready = 1'b0; i2.force_sel = '0; i2.in_data = '0;
        for (int c = 0; c < 8; c++) i0.in_data[c*16 +: 16] = 16'(16'h1000 + c);
        for (int c = 0; c < 5; c++) i5.in_data[c*16 +: 16] = 16'(16'h5000 + c);
        for (int c = 0; c < 8; c++) i1.in_data[c*16 +: 16] = 16'(16'h2000 + c);
        for (int c = 0; c < 6; c++) i2.in_data[c*16 +: 16] = 16'(16'h3000 + c);

        // Reset state
        step();
        chk("rst_valid", 32'(i0.out_valid), 32'h0);
        chk("rst_data",  32'(i0.out_data),  32'h0);
        chk("rst_ch",    32'(i0.out_ch),    32'h0);
        i0.in_valid = 8'hFF; i0.out_ready = 1'b1;
        #1;
        chk("rst_ready", 32'(i0.in_ready),  32'h0);
        reset = 1'b0;
        #1;

        // Round-robin fairness, all channels requesting
        chk("rr_first_ready", 32'(i0.in_ready), 32'h01);
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("rr_ch%0d", k),    32'(i0.out_ch),    32'(k % 8));
            chk($sformatf("rr_data%0d", k),  32'(i0.out_data),  32'(16'h1000 + (k % 8)));
            chk($sformatf("rr_valid%0d", k), 32'(i0.out_valid), 32'h1);
            chk($sformatf("rr_rdy%0d", k),   32'(i0.in_ready),  32'(8'h01 << ((k + 1) % 8)));
        end

        // Back-pressure: load BEEF from channel 1, then stall 3 cycles
        i0.in_valid = 8'h02;
        i0.in_data[1*16 +: 16] = 16'hBEEF;
        step();
        chk("bp_load", 32'(i0.out_data), 32'hBEEF);
        i0.out_ready = 1'b0;
        i0.in_valid  = 8'hFF;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_rdy%0d", k),   32'(i0.in_ready),  32'h0);
            chk($sformatf("bp_data%0d", k),  32'(i0.out_data),  32'hBEEF);
            chk($sformatf("bp_valid%0d", k), 32'(i0.out_valid), 32'h1);
            step();
        end
        i0.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(i0.in_ready), 32'h04);
        step();
        chk("bp_refill_data",  32'(i0.out_data),  32'h1002);
        chk("bp_refill_ch",    32'(i0.out_ch),    32'h2);
        chk("bp_refill_valid", 32'(i0.out_valid), 32'h1);
        i0.in_valid = '0;

        // Sparse requests with wrap, N=5
        i5.out_ready = 1'b1;
        i5.in_valid  = 5'b00010;
        #1;
        chk("sp_rdy_setup", 32'(i5.in_ready), 32'h02);
        step();
        chk("sp_ch_setup", 32'(i5.out_ch), 32'h1);
        i5.in_valid = 5'b10010;
        #1;
        chk("sp_rdy_a", 32'(i5.in_ready), 32'h10);
        step();
        chk("sp_ch_a",   32'(i5.out_ch),   32'h4);
        chk("sp_data_a", 32'(i5.out_data), 32'h5004);
        chk("sp_rdy_b",  32'(i5.in_ready), 32'h02);
        step();
        chk("sp_ch_b",   32'(i5.out_ch),   32'h1);
        step();
        chk("sp_ch_c",   32'(i5.out_ch),   32'h4);
        i5.in_valid = '0;

        // Fixed priority
        i1.out_ready = 1'b1;
        i1.in_valid  = 8'b1010_0100;
        #1;
        chk("fp_rdy", 32'(i1.in_ready), 32'h04);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("fp_ch%0d", k), 32'(i1.out_ch), 32'h2);
        end
        i1.in_valid = 8'hA0;
        #1;
        chk("fp_rdy5", 32'(i1.in_ready), 32'h20);
        step();
        chk("fp_ch5", 32'(i1.out_ch), 32'h5);
        i1.in_valid = 8'h80;
        step();
        chk("fp_ch7",   32'(i1.out_ch),   32'h7);
        chk("fp_data7", 32'(i1.out_data), 32'h2007);
        i1.in_valid = '0;

        // Forced select, N=6
        i2.out_ready = 1'b1;
        i2.force_sel = 3'd3;
        i2.in_valid  = 6'b111111;
        #1;
        chk("fs_rdy3", 32'(i2.in_ready), 32'h08);
        step();
        chk("fs_ch3",   32'(i2.out_ch),   32'h3);
        chk("fs_data3", 32'(i2.out_data), 32'h3003);
        i2.force_sel = 3'd7;
        #1;
        chk("fs_rdy_oor",   32'(i2.in_ready),  32'h0);
        chk("fs_valid_pre", 32'(i2.out_valid), 32'h1);
        step();
        chk("fs_valid_drained", 32'(i2.out_valid), 32'h0);
        chk("fs_data_hold",     32'(i2.out_data),  32'h3003);
        chk("fs_ch_hold",       32'(i2.out_ch),    32'h3);

        // Reset mid-stream on the round-robin unit
        i0.in_valid = 8'hFF;
        step();
        chk("mr_pre_valid", 32'(i0.out_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_valid", 32'(i0.out_valid), 32'h0);
        chk("mr_data",  32'(i0.out_data),  32'h0);
        chk("mr_ch",    32'(i0.out_ch),    32'h0);
        chk("mr_rdy",   32'(i0.in_ready),  32'h0);
        step();
        chk("mr_hold_valid", 32'(i0.out_valid), 32'h0);
        reset = 1'b0;
        #1;
        chk("mr_first_rdy", 32'(i0.in_ready), 32'h01);
        step();
        chk("mr_first_ch",   32'(i0.out_ch),   32'h0);
        chk("mr_first_data", 32'(i0.out_data), 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
